// File: rtl/int_res_station.sv
// Integer reservation station: holds issued ALU ops until operands arrive,
// snoops the CDB, and dispatches the oldest ready op to the ALU.
module int_res_station #(
  parameter int LENGTH = 32,
  parameter int TAG_W  = 6,
  parameter int DEPTH  = 4
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         flush,
  input  logic                         issue_valid,
  output logic                         issue_ready,
  input  logic [3:0]                   issue_op,
  input  logic [TAG_W-1:0]             issue_rd_tag,
  input  logic                         issue_rs1_rdy,
  input  logic [TAG_W-1:0]             issue_rs1_tag,
  input  logic [LENGTH-1:0]            issue_rs1_data,
  input  logic                         issue_rs2_rdy,
  input  logic [TAG_W-1:0]             issue_rs2_tag,
  input  logic [LENGTH-1:0]            issue_rs2_data,
  input  logic                         cdb_valid,
  input  logic [TAG_W-1:0]             cdb_tag,
  input  logic [LENGTH-1:0]            cdb_data,
  output logic                         exe_valid,
  input  logic                         exe_ready,
  output logic [3:0]                   exe_op,
  output logic [LENGTH-1:0]            exe_a,
  output logic [LENGTH-1:0]            exe_b,
  output logic [TAG_W-1:0]             exe_tag,
  output logic [$clog2(DEPTH+1)-1:0]   occupancy
);

  localparam int OW = $clog2(DEPTH+1);
  localparam int IW = $clog2(DEPTH);

  logic [DEPTH-1:0]  busy_q;
  logic [DEPTH-1:0]  s1r_q;
  logic [DEPTH-1:0]  s2r_q;
  logic [3:0]        op_q  [DEPTH];
  logic [TAG_W-1:0]  rd_q  [DEPTH];
  logic [TAG_W-1:0]  s1t_q [DEPTH];
  logic [TAG_W-1:0]  s2t_q [DEPTH];
  logic [LENGTH-1:0] s1d_q [DEPTH];
  logic [LENGTH-1:0] s2d_q [DEPTH];
  // old_q[i][j] set: entry i was issued before entry j
  logic [DEPTH-1:0]  old_q [DEPTH];
  logic [OW-1:0]     occ_q;

  logic [DEPTH-1:0]  rdy;
  logic [DEPTH-1:0]  sel;
  logic [IW-1:0]     sel_idx;
  logic [IW-1:0]     free_idx;
  logic              do_issue;
  logic              do_disp;
  logic              byp1;
  logic              byp2;

  assign issue_ready = (occ_q < OW'(DEPTH));
  assign occupancy   = occ_q;
  assign do_issue    = issue_valid & issue_ready;
  assign do_disp     = exe_valid & exe_ready;
  assign byp1 = cdb_valid & (cdb_tag == issue_rs1_tag);
  assign byp2 = cdb_valid & (cdb_tag == issue_rs2_tag);

  // Pick the oldest ready entry and the lowest free slot
  always_comb begin
    rdy      = busy_q & s1r_q & s2r_q;
    sel      = '0;
    sel_idx  = '0;
    free_idx = '0;
    exe_valid = |rdy;
    exe_op   = '0;
    exe_a    = '0;
    exe_b    = '0;
    exe_tag  = '0;
    for (int i = 0; i < DEPTH; i++) begin
      sel[i] = rdy[i];
      for (int j = 0; j < DEPTH; j++) begin
        if (rdy[j] && old_q[j][i]) sel[i] = 1'b0;
      end
    end
    for (int i = 0; i < DEPTH; i++) begin
      if (sel[i]) begin
        sel_idx = IW'(i);
        exe_op  = op_q[i];
        exe_a   = s1d_q[i];
        exe_b   = s2d_q[i];
        exe_tag = rd_q[i];
      end
    end
    for (int i = DEPTH-1; i >= 0; i--) begin
      if (!busy_q[i]) free_idx = IW'(i);
    end
  end

  // Entry state, CDB capture, age tracking and occupancy
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      busy_q <= '0;
      occ_q  <= '0;
      for (int i = 0; i < DEPTH; i++) old_q[i] <= '0;
    end else if (flush) begin
      busy_q <= '0;
      occ_q  <= '0;
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        if (busy_q[i] && !s1r_q[i] && cdb_valid
            && cdb_tag == s1t_q[i]) begin
          s1r_q[i] <= 1'b1;
          s1d_q[i] <= cdb_data;
        end
        if (busy_q[i] && !s2r_q[i] && cdb_valid
            && cdb_tag == s2t_q[i]) begin
          s2r_q[i] <= 1'b1;
          s2d_q[i] <= cdb_data;
        end
      end
      if (do_disp) busy_q[sel_idx] <= 1'b0;
      if (do_issue) begin
        busy_q[free_idx] <= 1'b1;
        op_q[free_idx]   <= issue_op;
        rd_q[free_idx]   <= issue_rd_tag;
        s1t_q[free_idx]  <= issue_rs1_tag;
        s2t_q[free_idx]  <= issue_rs2_tag;
        s1r_q[free_idx]  <= issue_rs1_rdy | byp1;
        s2r_q[free_idx]  <= issue_rs2_rdy | byp2;
        s1d_q[free_idx]  <= issue_rs1_rdy ? issue_rs1_data : cdb_data;
        s2d_q[free_idx]  <= issue_rs2_rdy ? issue_rs2_data : cdb_data;
        old_q[free_idx]  <= '0;
        for (int j = 0; j < DEPTH; j++) begin
          if (IW'(j) != free_idx) old_q[j][free_idx] <= 1'b1;
        end
      end
      if (do_issue && !do_disp) occ_q <= occ_q + OW'(1);
      else if (do_disp && !do_issue) occ_q <= occ_q - OW'(1);
    end
  end

endmodule

// File: tb/tb_int_res_station.sv
// Bench for int_res_station: directed scenarios plus random traffic
// checked against an issue-ordered queue model.
module tb_int_res_station;

  localparam int LENGTH = 32;
  localparam int TAG_W  = 6;
  localparam int DEPTH  = 4;

  logic              clk = 1'b0;
  logic              rst_n, flush;
  logic              issue_valid, issue_ready;
  logic [3:0]        issue_op;
  logic [TAG_W-1:0]  issue_rd_tag, issue_rs1_tag, issue_rs2_tag;
  logic              issue_rs1_rdy, issue_rs2_rdy;
  logic [LENGTH-1:0] issue_rs1_data, issue_rs2_data;
  logic              cdb_valid;
  logic [TAG_W-1:0]  cdb_tag;
  logic [LENGTH-1:0] cdb_data;
  logic              exe_valid, exe_ready;
  logic [3:0]        exe_op;
  logic [LENGTH-1:0] exe_a, exe_b;
  logic [TAG_W-1:0]  exe_tag;
  logic [2:0]        occupancy;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [3:0]        op;
    logic [TAG_W-1:0]  rd;
    bit                r1;
    logic [TAG_W-1:0]  t1;
    logic [LENGTH-1:0] d1;
    bit                r2;
    logic [TAG_W-1:0]  t2;
    logic [LENGTH-1:0] d2;
  } ent_t;

  ent_t mq[$];

  always #5 clk = ~clk;

  int_res_station #(.LENGTH(LENGTH), .TAG_W(TAG_W), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .issue_valid(issue_valid), .issue_ready(issue_ready),
    .issue_op(issue_op), .issue_rd_tag(issue_rd_tag),
    .issue_rs1_rdy(issue_rs1_rdy), .issue_rs1_tag(issue_rs1_tag),
    .issue_rs1_data(issue_rs1_data),
    .issue_rs2_rdy(issue_rs2_rdy), .issue_rs2_tag(issue_rs2_tag),
    .issue_rs2_data(issue_rs2_data),
    .cdb_valid(cdb_valid), .cdb_tag(cdb_tag), .cdb_data(cdb_data),
    .exe_valid(exe_valid), .exe_ready(exe_ready),
    .exe_op(exe_op), .exe_a(exe_a), .exe_b(exe_b),
    .exe_tag(exe_tag), .occupancy(occupancy)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    rst_n = 1'b1; flush = 1'b0;
    issue_valid = 1'b0; issue_op = '0; issue_rd_tag = '0;
    issue_rs1_rdy = 1'b0; issue_rs1_tag = '0; issue_rs1_data = '0;
    issue_rs2_rdy = 1'b0; issue_rs2_tag = '0; issue_rs2_data = '0;
    cdb_valid = 1'b0; cdb_tag = '0; cdb_data = '0;
    exe_ready = 1'b1;
  endtask

  task automatic drive_issue(input logic [3:0] op, input logic [5:0] rd,
                             input bit r1, input logic [5:0] t1,
                             input logic [31:0] d1,
                             input bit r2, input logic [5:0] t2,
                             input logic [31:0] d2);
    issue_valid = 1'b1; issue_op = op; issue_rd_tag = rd;
    issue_rs1_rdy = r1; issue_rs1_tag = t1; issue_rs1_data = d1;
    issue_rs2_rdy = r2; issue_rs2_tag = t2; issue_rs2_data = d2;
  endtask

  task automatic test_reset();
    idle();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    checks++; if (issue_ready !== 1'b1) begin errors++;
      $display("FAIL reset_issue_ready got %0b exp 1", issue_ready); end
    checks++; if (exe_valid !== 1'b0) begin errors++;
      $display("FAIL reset_exe_valid got %0b exp 0", exe_valid); end
    checks++; if (occupancy !== 3'd0) begin errors++;
      $display("FAIL reset_occ got %0d exp 0", occupancy); end
    checks++; if (exe_a !== '0 || exe_b !== '0) begin errors++;
      $display("FAIL reset_ab got %0h/%0h exp 0/0", exe_a, exe_b); end
  endtask

  task automatic test_basic();
    drive_issue(4'b0000, 6'd3, 1'b1, 6'd0, 32'd5, 1'b1, 6'd0, 32'd7);
    exe_ready = 1'b1;
    tick();
    issue_valid = 1'b0;
    checks++; if (exe_valid !== 1'b1 || exe_a !== 32'd5 || exe_b !== 32'd7
                  || exe_tag !== 6'd3 || exe_op !== 4'd0) begin errors++;
      $display("FAIL basic_exe got v%0b a%0h b%0h t%0d exp v1 a5 b7 t3",
               exe_valid, exe_a, exe_b, exe_tag); end
    tick();
    checks++; if (occupancy !== 3'd0 || exe_valid !== 1'b0) begin errors++;
      $display("FAIL basic_drain got occ%0d v%0b exp occ0 v0",
               occupancy, exe_valid); end
  endtask

  task automatic test_wakeup();
    drive_issue(4'd1, 6'd10, 1'b1, 6'd0, 32'd1, 1'b0, 6'd9, 32'hDEAD);
    tick();
    issue_valid = 1'b0;
    checks++; if (exe_valid !== 1'b0 || occupancy !== 3'd1) begin errors++;
      $display("FAIL wake_wait got v%0b occ%0d exp v0 occ1",
               exe_valid, occupancy); end
    cdb_valid = 1'b1; cdb_tag = 6'd8; cdb_data = 32'h55;
    tick();
    checks++; if (exe_valid !== 1'b0) begin errors++;
      $display("FAIL wake_wrong_tag got v%0b exp 0", exe_valid); end
    cdb_tag = 6'd9; cdb_data = 32'h20;
    tick();
    cdb_valid = 1'b0;
    checks++; if (exe_valid !== 1'b1 || exe_b !== 32'h20
                  || exe_a !== 32'd1 || exe_tag !== 6'd10) begin errors++;
      $display("FAIL wake_exe got v%0b a%0h b%0h t%0d exp v1 a1 b20 t10",
               exe_valid, exe_a, exe_b, exe_tag); end
    tick();
  endtask

  task automatic test_bypass();
    drive_issue(4'd2, 6'd13, 1'b0, 6'd12, 32'h0, 1'b1, 6'd0, 32'd3);
    cdb_valid = 1'b1; cdb_tag = 6'd12; cdb_data = 32'hFF;
    tick();
    issue_valid = 1'b0; cdb_valid = 1'b0;
    checks++; if (exe_valid !== 1'b1 || exe_a !== 32'hFF
                  || exe_b !== 32'd3) begin errors++;
      $display("FAIL bypass got v%0b a%0h b%0h exp v1 aff b3",
               exe_valid, exe_a, exe_b); end
    tick();
  endtask

  task automatic test_full_order();
    exe_ready = 1'b0;
    for (int k = 1; k <= 4; k++) begin
      drive_issue(4'(k), 6'(20 + k), 1'b0, 6'(k), 32'h0,
                  1'b1, 6'd0, 32'(k));
      tick();
    end
    checks++; if (issue_ready !== 1'b0 || occupancy !== 3'd4) begin errors++;
      $display("FAIL full_ready got r%0b occ%0d exp r0 occ4",
               issue_ready, occupancy); end
    drive_issue(4'd7, 6'd30, 1'b1, 6'd0, 32'd9, 1'b1, 6'd0, 32'd9);
    tick();
    issue_valid = 1'b0;
    checks++; if (occupancy !== 3'd4 || exe_valid !== 1'b0) begin errors++;
      $display("FAIL full_drop got occ%0d v%0b exp occ4 v0",
               occupancy, exe_valid); end
    cdb_valid = 1'b1; cdb_tag = 6'd4; cdb_data = 32'h44;
    tick();
    checks++; if (exe_valid !== 1'b1 || exe_tag !== 6'd24
                  || exe_a !== 32'h44) begin errors++;
      $display("FAIL order_wake4 got v%0b t%0d a%0h exp v1 t24 a44",
               exe_valid, exe_tag, exe_a); end
    cdb_tag = 6'd1; cdb_data = 32'h11;
    tick();
    cdb_valid = 1'b0;
    checks++; if (exe_tag !== 6'd21 || exe_a !== 32'h11) begin errors++;
      $display("FAIL order_oldest got t%0d a%0h exp t21 a11",
               exe_tag, exe_a); end
    exe_ready = 1'b1;
    tick();
    checks++; if (exe_tag !== 6'd24 || occupancy !== 3'd3) begin errors++;
      $display("FAIL order_second got t%0d occ%0d exp t24 occ3",
               exe_tag, occupancy); end
    tick();
    checks++; if (exe_valid !== 1'b0 || occupancy !== 3'd2) begin errors++;
      $display("FAIL order_done got v%0b occ%0d exp v0 occ2",
               exe_valid, occupancy); end
  endtask

  task automatic test_flush();
    exe_ready = 1'b0;
    drive_issue(4'd3, 6'd25, 1'b0, 6'd5, 32'h0, 1'b1, 6'd0, 32'd1);
    tick();
    checks++; if (occupancy !== 3'd3) begin errors++;
      $display("FAIL flush_pre got occ%0d exp 3", occupancy); end
    drive_issue(4'd4, 6'd26, 1'b1, 6'd0, 32'd1, 1'b1, 6'd0, 32'd2);
    flush = 1'b1;
    tick();
    flush = 1'b0; issue_valid = 1'b0;
    checks++; if (occupancy !== 3'd0 || exe_valid !== 1'b0
                  || issue_ready !== 1'b1) begin errors++;
      $display("FAIL flush_post got occ%0d v%0b r%0b exp occ0 v0 r1",
               occupancy, exe_valid, issue_ready); end
    for (int k = 0; k < 3; k++) begin
      drive_issue(4'd5, 6'(40 + k), 1'b0, 6'(50 + k), 32'h0,
                  1'b1, 6'd0, 32'd1);
      tick();
    end
    checks++; if (occupancy !== 3'd3) begin errors++;
      $display("FAIL rst_pre got occ%0d exp 3", occupancy); end
    drive_issue(4'd4, 6'd26, 1'b1, 6'd0, 32'd1, 1'b1, 6'd0, 32'd2);
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1; issue_valid = 1'b0;
    checks++; if (occupancy !== 3'd0 || exe_valid !== 1'b0
                  || issue_ready !== 1'b1) begin errors++;
      $display("FAIL rst_post got occ%0d v%0b r%0b exp occ0 v0 r1",
               occupancy, exe_valid, issue_ready); end
    exe_ready = 1'b1;
  endtask

  task automatic test_random();
    ent_t e;
    bit   ev;
    int   ei;
    bit   acc;
    idle();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    mq.delete();
    for (int c = 0; c < 600; c++) begin
      ev = 1'b0; ei = 0;
      foreach (mq[k]) if (!ev && mq[k].r1 && mq[k].r2) begin
        ev = 1'b1; ei = k;
      end
      checks++; if (exe_valid !== ev) begin errors++;
        $display("FAIL rnd_valid cyc %0d got %0b exp %0b", c, exe_valid, ev); end
      checks++; if (occupancy !== 3'(mq.size())
                    || issue_ready !== (mq.size() < DEPTH)) begin errors++;
        $display("FAIL rnd_occ cyc %0d got occ%0d r%0b exp occ%0d",
                 c, occupancy, issue_ready, mq.size()); end
      if (ev) begin
        checks++; if (exe_op !== mq[ei].op || exe_a !== mq[ei].d1
                      || exe_b !== mq[ei].d2 || exe_tag !== mq[ei].rd) begin
          errors++;
          $display("FAIL rnd_data cyc %0d got %0h %0h %0h %0d exp %0h %0h %0h %0d",
                   c, exe_op, exe_a, exe_b, exe_tag,
                   mq[ei].op, mq[ei].d1, mq[ei].d2, mq[ei].rd); end
      end else begin
        checks++; if (exe_op !== '0 || exe_a !== '0 || exe_b !== '0
                      || exe_tag !== '0) begin errors++;
          $display("FAIL rnd_idle cyc %0d got %0h %0h %0h %0d exp zeros",
                   c, exe_op, exe_a, exe_b, exe_tag); end
      end
      issue_valid    = ($urandom_range(0, 99) < 55);
      issue_op       = 4'($urandom);
      issue_rd_tag   = 6'($urandom_range(0, 63));
      issue_rs1_rdy  = ($urandom_range(0, 99) < 50);
      issue_rs1_tag  = 6'($urandom_range(0, 7));
      issue_rs1_data = $urandom;
      issue_rs2_rdy  = ($urandom_range(0, 99) < 50);
      issue_rs2_tag  = 6'($urandom_range(0, 7));
      issue_rs2_data = $urandom;
      cdb_valid      = ($urandom_range(0, 99) < 50);
      cdb_tag        = 6'($urandom_range(0, 7));
      cdb_data       = $urandom;
      exe_ready      = ($urandom_range(0, 99) < 60);
      flush          = ($urandom_range(0, 99) < 3);
      acc = issue_valid && (mq.size() < DEPTH);
      if (flush) begin
        mq.delete();
      end else begin
        foreach (mq[k]) begin
          e = mq[k];
          if (cdb_valid && !e.r1 && e.t1 == cdb_tag) begin
            e.r1 = 1'b1; e.d1 = cdb_data; end
          if (cdb_valid && !e.r2 && e.t2 == cdb_tag) begin
            e.r2 = 1'b1; e.d2 = cdb_data; end
          mq[k] = e;
        end
        if (ev && exe_ready) mq.delete(ei);
        if (acc) begin
          e.op = issue_op; e.rd = issue_rd_tag;
          e.t1 = issue_rs1_tag; e.t2 = issue_rs2_tag;
          e.r1 = issue_rs1_rdy || (cdb_valid && cdb_tag == issue_rs1_tag);
          e.d1 = issue_rs1_rdy ? issue_rs1_data : cdb_data;
          e.r2 = issue_rs2_rdy || (cdb_valid && cdb_tag == issue_rs2_tag);
          e.d2 = issue_rs2_rdy ? issue_rs2_data : cdb_data;
          mq.push_back(e);
        end
      end
      tick();
    end
    idle();
  endtask

  initial begin
    test_reset();
    test_basic();
    test_wakeup();
    test_bypass();
    test_full_order();
    test_flush();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
